riscv_v_reduct_seq: RTL and testbench

//  Multi-pass sequencer for vector reductions (vred*). Accepts one reduction request, issues

---
 rtl/riscv_v_pkg.sv | 22 ++
 rtl/riscv_v_reduct_pass_decode.sv | 38 +++
 rtl/riscv_v_reduct_seq.sv | 144 ++++++++++++++
 tb/tb_riscv_v_reduct_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_v_pkg.sv
// Shared constants and types for the vector reduction sequencer.
package riscv_v_pkg;

    localparam int unsigned RISCV_V_DATA_WIDTH       = 128;
    localparam int unsigned RISCV_V_NUM_VALID_OSIZES = 5;

    typedef enum logic [2:0] {
        Osize8   = 3'd0,
        Osize16  = 3'd1,
        Osize32  = 3'd2,
        Osize64  = 3'd3,
        Osize128 = 3'd4
    } osize_e;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } reduct_state_t;

endpackage

// File: rtl/riscv_v_reduct_pass_decode.sv
// Combinational per-pass control decode for the reduction sequencer.
module riscv_v_reduct_pass_decode #(
    parameter int unsigned NUM_OSIZES = 5,
    parameter int unsigned PASS_W     = 3
) (
    input  logic [PASS_W-1:0]     pass_cnt,
    input  logic [2:0]            sew,
    output logic                  is_reduct,
    output logic                  is_reduct_n,
    output logic [NUM_OSIZES-1:0] osize_vector,
    output logic [NUM_OSIZES-1:0] is_greater_osize_vector,
    output logic                  pass_last
);

    logic [PASS_W-1:0] last_pass;
    logic [PASS_W-1:0] work_osize;

    always_comb begin
        is_reduct               = 1'b0;
        is_reduct_n             = 1'b1;
        osize_vector            = '0;
        is_greater_osize_vector = '1;
        // Each pass halves the working width, so the final pass index is 4 - sew.
        last_pass               = PASS_W'(NUM_OSIZES - 1) - PASS_W'(sew);
        work_osize              = PASS_W'(NUM_OSIZES - 1) - pass_cnt;
        pass_last               = (pass_cnt == last_pass);

        if (pass_cnt != '0) begin
            is_reduct   = 1'b1;
            is_reduct_n = 1'b0;
            for (int k = 0; k < int'(NUM_OSIZES); k++) begin
                osize_vector[k]            = (k == int'(work_osize));
                is_greater_osize_vector[k] = (k >= 1) && (k <= int'(work_osize));
            end
        end
    end

endmodule

// File: rtl/riscv_v_reduct_seq.sv
// Multi-pass vector reduction sequencer: issues passes to the ALU and feeds results back.
module riscv_v_reduct_seq
    import riscv_v_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RISCV_V_DATA_WIDTH,
    parameter int unsigned NUM_OSIZES = RISCV_V_NUM_VALID_OSIZES,
    parameter int unsigned PASS_W     = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_sew,
    input  logic                  kill,
    output logic                  alu_issue_valid,
    input  logic                  alu_issue_ready,
    input  logic                  alu_result_valid,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic                  is_reduct,
    output logic                  is_reduct_n,
    output logic [NUM_OSIZES-1:0] osize_vector,
    output logic [NUM_OSIZES-1:0] is_greater_osize_vector,
    output logic [DATA_WIDTH-1:0] result_q,
    output logic                  done_valid,
    input  logic                  done_ready,
    output logic                  done_err,
    output logic                  busy
);

    reduct_state_t         state_q, state_d;
    logic [PASS_W-1:0]     pass_cnt_q, pass_cnt_d;
    logic [2:0]            sew_q, sew_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] result_d;
    logic                  last_q, last_d;

    logic                  is_reduct_d, is_reduct_n_d;
    logic [NUM_OSIZES-1:0] osize_vector_d, is_greater_d;

    logic                  dec_is_reduct, dec_is_reduct_n, dec_last;
    logic [NUM_OSIZES-1:0] dec_osize, dec_greater;
    logic                  run_d;

    // Decode the pass about to run so the controls are registered alongside the state.
    riscv_v_reduct_pass_decode #(
        .NUM_OSIZES (NUM_OSIZES),
        .PASS_W     (PASS_W)
    ) u_pass_decode (
        .pass_cnt                (pass_cnt_d),
        .sew                     (sew_d),
        .is_reduct               (dec_is_reduct),
        .is_reduct_n             (dec_is_reduct_n),
        .osize_vector            (dec_osize),
        .is_greater_osize_vector (dec_greater),
        .pass_last               (dec_last)
    );

    always_comb begin
        state_d    = state_q;
        pass_cnt_d = pass_cnt_q;
        sew_d      = sew_q;
        err_d      = err_q;
        result_d   = result_q;

        if (kill) begin
            state_d    = StIdle;
            pass_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        state_d    = StIssue;
                        pass_cnt_d = '0;
                        err_d      = (req_sew > Osize128);
                        sew_d      = (req_sew > Osize128) ? Osize128 : req_sew;
                    end
                end
                StIssue: begin
                    if (alu_issue_ready) begin
                        state_d = StWait;
                    end
                end
                StWait: begin
                    if (alu_result_valid) begin
                        result_d = alu_result;
                        if (last_q) begin
                            state_d = StDone;
                        end else begin
                            pass_cnt_d = pass_cnt_q + 1'b1;
                            state_d    = StIssue;
                        end
                    end
                end
                StDone: begin
                    if (done_ready) begin
                        state_d    = StIdle;
                        pass_cnt_d = '0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        run_d          = (state_d == StIssue) || (state_d == StWait);
        is_reduct_d    = run_d ? dec_is_reduct : 1'b0;
        is_reduct_n_d  = run_d ? dec_is_reduct_n : 1'b1;
        osize_vector_d = run_d ? dec_osize : '0;
        is_greater_d   = run_d ? dec_greater : '1;
        last_d         = run_d ? dec_last : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q                 <= StIdle;
            pass_cnt_q              <= '0;
            sew_q                   <= '0;
            err_q                   <= 1'b0;
            result_q                <= '0;
            last_q                  <= 1'b0;
            is_reduct               <= 1'b0;
            is_reduct_n             <= 1'b1;
            osize_vector            <= '0;
            is_greater_osize_vector <= '1;
        end else begin
            state_q                 <= state_d;
            pass_cnt_q              <= pass_cnt_d;
            sew_q                   <= sew_d;
            err_q                   <= err_d;
            result_q                <= result_d;
            last_q                  <= last_d;
            is_reduct               <= is_reduct_d;
            is_reduct_n             <= is_reduct_n_d;
            osize_vector            <= osize_vector_d;
            is_greater_osize_vector <= is_greater_d;
        end
    end

    assign req_ready       = (state_q == StIdle);
    assign busy            = (state_q != StIdle);
    assign alu_issue_valid = (state_q == StIssue);
    assign done_valid      = (state_q == StDone);
    assign done_err        = (state_q == StDone) && err_q;

endmodule

// File: tb/tb_riscv_v_reduct_seq.sv
// Directed self-checking bench for the vector reduction sequencer.
module tb_riscv_v_reduct_seq;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_sew;
    logic         kill;
    logic         alu_issue_valid;
    logic         alu_issue_ready;
    logic         alu_result_valid;
    logic [127:0] alu_result;
    logic         is_reduct;
    logic         is_reduct_n;
    logic [4:0]   osize_vector;
    logic [4:0]   is_greater_osize_vector;
    logic [127:0] result_q;
    logic         done_valid;
    logic         done_ready;
    logic         done_err;
    logic         busy;

    logic [11:0]  ctrl;
    int           n_tests;
    int           n_fail;

    localparam logic [11:0] CtrlRst = {1'b0, 1'b1, 5'b00000, 5'b11111};

    riscv_v_reduct_seq dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .req_valid               (req_valid),
        .req_ready               (req_ready),
        .req_sew                 (req_sew),
        .kill                    (kill),
        .alu_issue_valid         (alu_issue_valid),
        .alu_issue_ready         (alu_issue_ready),
        .alu_result_valid        (alu_result_valid),
        .alu_result              (alu_result),
        .is_reduct               (is_reduct),
        .is_reduct_n             (is_reduct_n),
        .osize_vector            (osize_vector),
        .is_greater_osize_vector (is_greater_osize_vector),
        .result_q                (result_q),
        .done_valid              (done_valid),
        .done_ready              (done_ready),
        .done_err                (done_err),
        .busy                    (busy)
    );

    assign ctrl = {is_reduct, is_reduct_n, osize_vector, is_greater_osize_vector};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Hand-written pass plan: {is_reduct, is_reduct_n, osize_vector, is_greater}.
    function automatic logic [11:0] exp_ctrl(input int p);
        case (p)
            0:       return {1'b0, 1'b1, 5'b00000, 5'b11111};
            1:       return {1'b1, 1'b0, 5'b01000, 5'b01110};
            2:       return {1'b1, 1'b0, 5'b00100, 5'b00110};
            3:       return {1'b1, 1'b0, 5'b00010, 5'b00010};
            default: return {1'b1, 1'b0, 5'b00001, 5'b00000};
        endcase
    endfunction

    function automatic logic [127:0] pass_data(input int p);
        return {4{32'hC0DE_0000 + 32'(p)}};
    endfunction

    task automatic start_req(input logic [2:0] sew);
        check("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1;
        req_sew   = sew;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic do_pass(input int p, input int stall, input logic [127:0] data);
        check($sformatf("issue_vld_p%0d", p), alu_issue_valid, 1'b1);
        check($sformatf("issue_ctrl_p%0d", p), ctrl, exp_ctrl(p));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check($sformatf("stall_vld_p%0d", p), alu_issue_valid, 1'b1);
            check($sformatf("stall_ctrl_p%0d", p), ctrl, exp_ctrl(p));
        end
        alu_issue_ready = 1'b1;
        @(negedge clk);
        alu_issue_ready = 1'b0;
        check($sformatf("wait_ctrl_p%0d", p), ctrl, exp_ctrl(p));
        check($sformatf("wait_vld_p%0d", p), alu_issue_valid, 1'b0);
        alu_result_valid = 1'b1;
        alu_result       = data;
        @(negedge clk);
        alu_result_valid = 1'b0;
        check($sformatf("result_p%0d", p), result_q, data);
    endtask

    task automatic finish_req(input logic err, input logic [127:0] data, input int hold);
        check("done_valid", done_valid, 1'b1);
        check("done_err", done_err, err);
        check("done_result", result_q, data);
        check("done_ctrl", ctrl, CtrlRst);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_done_valid", done_valid, 1'b1);
            check("hold_result", result_q, data);
        end
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
        check("post_done_ready", req_ready, 1'b1);
        check("post_done_valid", done_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests          = 0;
        n_fail           = 0;
        rst_n            = 1'b0;
        req_valid        = 1'b0;
        req_sew          = 3'd0;
        kill             = 1'b0;
        alu_issue_ready  = 1'b0;
        alu_result_valid = 1'b0;
        alu_result       = '0;
        done_ready       = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_req_ready", req_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_ctrl", ctrl, CtrlRst);
        check("rst_result", result_q, 128'd0);
        check("rst_done", {done_valid, done_err, alu_issue_valid}, 3'b000);
        rst_n = 1'b1;
        @(negedge clk);

        // sew=0: five passes through every working osize.
        start_req(3'd0);
        for (int p = 0; p < 5; p++) do_pass(p, 0, pass_data(p));
        finish_req(1'b0, pass_data(4), 0);

        // sew=4: one pass, no feedback.
        start_req(3'd4);
        do_pass(0, 0, {16{8'hA5}});
        finish_req(1'b0, {16{8'hA5}}, 0);

        // sew=2 with issue stalled for 10 cycles on the first pass.
        start_req(3'd2);
        do_pass(0, 10, pass_data(10));
        do_pass(1, 0, pass_data(11));
        do_pass(2, 0, pass_data(12));
        finish_req(1'b0, pass_data(12), 0);

        // Kill in WAIT of pass 2, then a late result must be ignored.
        start_req(3'd0);
        do_pass(0, 0, pass_data(20));
        do_pass(1, 0, pass_data(21));
        alu_issue_ready = 1'b1;
        @(negedge clk);
        alu_issue_ready = 1'b0;
        check("kill_wait_ctrl", ctrl, exp_ctrl(2));
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_busy", busy, 1'b0);
        check("kill_req_ready", req_ready, 1'b1);
        check("kill_ctrl", ctrl, CtrlRst);
        alu_result_valid = 1'b1;
        alu_result       = {4{32'hDEAD_BEEF}};
        @(negedge clk);
        alu_result_valid = 1'b0;
        check("late_result_held", result_q, pass_data(21));
        check("late_busy", busy, 1'b0);

        // Kill together with a request in IDLE drops the request.
        req_valid = 1'b1;
        kill      = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        kill      = 1'b0;
        check("kill_req_drop", busy, 1'b0);

        // Illegal sew: single pass, error flagged, done held while not accepted.
        start_req(3'd6);
        do_pass(0, 0, pass_data(30));
        finish_req(1'b1, pass_data(30), 4);
        check("err_cleared", done_err, 1'b0);

        // Issue ready and result valid together in ISSUE: only the issue is taken.
        start_req(3'd4);
        alu_issue_ready  = 1'b1;
        alu_result_valid = 1'b1;
        alu_result       = {4{32'hBAD0_BAD0}};
        @(negedge clk);
        alu_issue_ready  = 1'b0;
        alu_result_valid = 1'b0;
        check("same_cycle_wait", alu_issue_valid, 1'b0);
        check("same_cycle_busy", {busy, done_valid}, 2'b10);
        check("same_cycle_result", result_q, pass_data(30));
        alu_result_valid = 1'b1;
        alu_result       = pass_data(31);
        @(negedge clk);
        alu_result_valid = 1'b0;
        finish_req(1'b0, pass_data(31), 0);

        // Asynchronous reset in the middle of WAIT.
        start_req(3'd0);
        do_pass(0, 0, pass_data(40));
        alu_issue_ready = 1'b1;
        @(negedge clk);
        alu_issue_ready = 1'b0;
        check("pre_rst_ctrl", ctrl, exp_ctrl(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_req_ready", req_ready, 1'b1);
        check("arst_ctrl", ctrl, CtrlRst);
        check("arst_result", result_q, 128'd0);
        check("arst_issue_vld", alu_issue_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
